gate2_test_sequencer: RTL and testbench

Self-checking stimulus/response stage for 2-input combinational gates (nand_gate and siblings). It drives the gate's `a`/`b` inputs through all four input combinations in order and samples the gate's `y` after a programmable settle time. It compares each sample against a parameterised truth table and reports a per-vector fail map, an error count and a pass flag. It sits directly upstream and downstream of the gate under test: its outputs feed the gate's inputs, and the gate's output returns to it.

---
 rtl/gate2_test_sequencer_if.sv | 56 +++++
 rtl/gate2_test_sequencer.sv | 124 ++++++++++++
 tb/tb_gate2_test_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate2_test_sequencer_if.sv
// ---------------------------------------------------------------------------
// gate2_test_sequencer_if
//
// Bundles every signal that passes between the gate test sequencer, the
// 2-input gate under test and whoever starts runs and reads the results.
//
// Signals:
//   start      - run request to the sequencer
//   y          - output of the gate under test, returned to the sequencer
//   a, b       - gate inputs driven by the sequencer
//   busy       - sequencer is stepping through vectors
//   done       - run finished, results are valid and held
//   pass       - run finished with no mismatching vectors
//   err_count  - number of mismatching vectors (0..4)
//   fail_vec   - bit i set if vector {a,b} = i mismatched
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment: the controller issuing start plus the gate
//            returning y
// ---------------------------------------------------------------------------
interface gate2_test_sequencer_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport slave (
    input  start,
    input  y,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec
  );

  modport master (
    output start,
    output y,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec
  );
endinterface

// File: rtl/gate2_test_sequencer.sv
// ---------------------------------------------------------------------------
// gate2_test_sequencer
//
// Stimulus/response stage for a 2-input combinational gate. Walks {a,b}
// through 00, 01, 10, 11, holds each vector for SETTLE+1 cycles, samples the
// gate output y on the last of those cycles and compares it with TRUTH.
// Reports a per-vector fail map, an error count and a pass flag.
//
// Parameters:
//   TRUTH  - expected y per vector, bit i for {a,b} = i (default NAND)
//   SETTLE - cycles a/b are held before the check cycle (1..255, 0 acts as 1)
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of gate2_test_sequencer_if (start, y in; a, b,
//            busy, done, pass, err_count, fail_vec out)
// ---------------------------------------------------------------------------
module gate2_test_sequencer #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate2_test_sequencer_if.slave bus
);

  // A settle time of 0 is treated as 1 so every vector still gets one cycle
  // in SETTLE before its check cycle.
  localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [7:0]  CNT_LAST   = 8'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       mismatch;

  // Mismatch is the default; only a clean equality clears it. An X or Z on
  // y makes the equality unknown, the if is not taken, and the vector is
  // flagged as failing instead of silently passing.
  always_comb begin
    mismatch = 1'b1;
    if (bus.y == TRUTH[idx]) begin
      mismatch = 1'b0;
    end
  end

  // Single FSM with all outputs registered. IDLE and DONE share the start
  // handling since a start from DONE behaves exactly like one from IDLE;
  // without start, DONE simply holds its results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= 2'd0;
      cnt           <= 8'd0;
      bus.a         <= 1'b0;
      bus.b         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= 3'd0;
      bus.fail_vec  <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state         <= S_SETTLE;
            idx           <= 2'd0;
            cnt           <= 8'd0;
            bus.a         <= 1'b0;
            bus.b         <= 1'b0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
            bus.fail_vec  <= 4'd0;
          end
        end

        S_SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_CHECK: begin
          // At most four vectors are checked, so err_count tops out at 4
          // and can never wrap.
          if (mismatch) begin
            bus.err_count     <= bus.err_count + 3'd1;
            bus.fail_vec[idx] <= 1'b1;
          end
          if (idx == 2'd3) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.err_count == 3'd0) && !mismatch;
            bus.a    <= 1'b0;
            bus.b    <= 1'b0;
          end else begin
            state            <= S_SETTLE;
            idx              <= idx + 2'd1;
            cnt              <= 8'd0;
            {bus.a, bus.b}   <= idx + 2'd1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate2_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gate2_test_sequencer
//
// Directed bench for gate2_test_sequencer. Two instances are used: the
// default NAND/SETTLE=2 sequencer driving a modelled gate whose behaviour is
// selectable (good NAND, stuck-at-1, AND), and an XOR-table/SETTLE=1
// sequencer driving an XOR gate.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_gate2_test_sequencer;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  // 0 = correct NAND, 1 = stuck-at-1, 2 = AND (wrong gate type)
  int gate_mode;

  // Per-cycle observations recorded by start_and_wait: index j holds what
  // was seen at the falling edge after rising edge k+j (k = start edge).
  logic [1:0] ab_log   [0:63];
  logic       busy_log [0:63];
  logic       done_at0;
  logic       pass_at0;
  logic [2:0] err_at0;
  logic [3:0] fail_at0;

  gate2_test_sequencer_if bus ();
  gate2_test_sequencer_if bus_x ();

  // The gate under test for the default sequencer; its behaviour follows
  // gate_mode so the same instance can model good and faulty gates.
  assign bus.y = (gate_mode == 0) ? ~(bus.a & bus.b) :
                 (gate_mode == 1) ? 1'b1 :
                                    (bus.a & bus.b);

  // XOR gate for the second sequencer.
  assign bus_x.y = bus_x.a ^ bus_x.b;

  gate2_test_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  gate2_test_sequencer #(
    .TRUTH  (4'b0110),
    .SETTLE (1)
  ) dut_x (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_x.slave)
  );

  // 100 MHz free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulses start on the selected sequencer (0 = dut, 1 = dut_x), optionally
  // holding it high for the whole run, and counts rising edges from the start
  // edge until done is seen. cycles is -1 if done never appears in 40 edges.
  task automatic start_and_wait(input int sel, input bit hold, output int cycles);
    cycles = -1;
    @(negedge clk);
    if (sel == 0) bus.start = 1'b1;
    else          bus_x.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      bus.start   = 1'b0;
      bus_x.start = 1'b0;
    end
    if (sel == 0) begin
      ab_log[0]   = {bus.a, bus.b};
      busy_log[0] = bus.busy;
      done_at0    = bus.done;
      pass_at0    = bus.pass;
      err_at0     = bus.err_count;
      fail_at0    = bus.fail_vec;
    end else begin
      ab_log[0]   = {bus_x.a, bus_x.b};
      busy_log[0] = bus_x.busy;
      done_at0    = bus_x.done;
      pass_at0    = bus_x.pass;
      err_at0     = bus_x.err_count;
      fail_at0    = bus_x.fail_vec;
    end
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel == 0) begin
        ab_log[j]   = {bus.a, bus.b};
        busy_log[j] = bus.busy;
      end else begin
        ab_log[j]   = {bus_x.a, bus_x.b};
        busy_log[j] = bus_x.busy;
      end
      if ((sel == 0 && bus.done) || (sel == 1 && bus_x.done)) begin
        cycles = j;
        break;
      end
    end
    bus.start   = 1'b0;
    bus_x.start = 1'b0;
  endtask

  // Reset asserted before any clock edge: every output must already be at
  // its reset value on both sequencers.
  task automatic test_reset();
    #1;
    checks++;
    if ({bus.a, bus.b, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut: got %b expected %b",
               {bus.a, bus.b, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec}, 12'd0);
    end
    checks++;
    if ({bus_x.a, bus_x.b, bus_x.busy, bus_x.done, bus_x.pass, bus_x.err_count, bus_x.fail_vec} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut_x: got %b expected %b",
               {bus_x.a, bus_x.b, bus_x.busy, bus_x.done, bus_x.pass, bus_x.err_count, bus_x.fail_vec}, 12'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Good NAND: vectors 00,01,10,11 each held three cycles, done 12 cycles
  // after the start edge with a clean result.
  task automatic test_correct_gate();
    int cycles;
    logic [1:0] exp_ab;
    gate_mode = 0;
    start_and_wait(0, 1'b0, cycles);
    checks++;
    if (cycles !== 12) begin
      errors++;
      $display("[TB] FAIL correct_done_cycle: got %0d expected 12", cycles);
    end
    checks++;
    if (busy_log[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL correct_busy_after_start: got %b expected 1", busy_log[0]);
    end
    for (int j = 0; j < 12; j++) begin
      exp_ab = 2'(j / 3);
      checks++;
      if (ab_log[j] !== exp_ab) begin
        errors++;
        $display("[TB] FAIL correct_ab_cycle%0d: got %b expected %b", j, ab_log[j], exp_ab);
      end
    end
    if (cycles == 12) begin
      checks++;
      if ({ab_log[12], busy_log[12]} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL correct_ab_busy_in_done: got %b expected 000", {ab_log[12], busy_log[12]});
      end
    end
    checks++;
    if ({bus.pass, bus.err_count, bus.fail_vec} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL correct_result: got pass=%b err=%0d fail=%b expected pass=1 err=0 fail=0000",
               bus.pass, bus.err_count, bus.fail_vec);
    end
    // Results must hold in DONE while start stays low.
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.done, bus.pass, bus.busy} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL correct_done_hold: got done/pass/busy=%b expected 110",
               {bus.done, bus.pass, bus.busy});
    end
  endtask

  // Gate output stuck at 1: only vector 11 (expected 0) mismatches.
  task automatic test_stuck_at_one();
    int cycles;
    gate_mode = 1;
    start_and_wait(0, 1'b0, cycles);
    checks++;
    if (cycles !== 12) begin
      errors++;
      $display("[TB] FAIL stuck1_done_cycle: got %0d expected 12", cycles);
    end
    checks++;
    if ({bus.pass, bus.err_count, bus.fail_vec} !== {1'b0, 3'd1, 4'b1000}) begin
      errors++;
      $display("[TB] FAIL stuck1_result: got pass=%b err=%0d fail=%b expected pass=0 err=1 fail=1000",
               bus.pass, bus.err_count, bus.fail_vec);
    end
  endtask

  // AND instead of NAND: every vector is inverted, so all four fail.
  task automatic test_wrong_gate();
    int cycles;
    gate_mode = 2;
    start_and_wait(0, 1'b0, cycles);
    checks++;
    if ({bus.done, bus.pass, bus.err_count, bus.fail_vec} !== {1'b1, 1'b0, 3'd4, 4'b1111}) begin
      errors++;
      $display("[TB] FAIL wrong_gate_result: got done=%b pass=%b err=%0d fail=%b expected done=1 pass=0 err=4 fail=1111",
               bus.done, bus.pass, bus.err_count, bus.fail_vec);
    end
  endtask

  // XOR table with SETTLE=1: two cycles per vector, done after 8.
  task automatic test_xor_table();
    int cycles;
    start_and_wait(1, 1'b0, cycles);
    checks++;
    if (cycles !== 8) begin
      errors++;
      $display("[TB] FAIL xor_done_cycle: got %0d expected 8", cycles);
    end
    checks++;
    if ({bus_x.pass, bus_x.err_count, bus_x.fail_vec} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL xor_result: got pass=%b err=%0d fail=%b expected pass=1 err=0 fail=0000",
               bus_x.pass, bus_x.err_count, bus_x.fail_vec);
    end
  endtask

  // Reset dropped between clock edges while vector 10 is settling. The AND
  // gate is used so err_count/fail_vec are non-zero beforehand.
  task automatic test_reset_mid_run();
    int cycles;
    gate_mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.a, bus.b, bus.err_count, bus.fail_vec} !== {2'b10, 3'd2, 4'b0011}) begin
      errors++;
      $display("[TB] FAIL midrun_before_reset: got ab=%b err=%0d fail=%b expected ab=10 err=2 fail=0011",
               {bus.a, bus.b}, bus.err_count, bus.fail_vec);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.a, bus.b, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL midrun_async_reset: got %b expected %b",
               {bus.a, bus.b, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec}, 12'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    gate_mode = 0;
    start_and_wait(0, 1'b0, cycles);
    checks++;
    if (cycles !== 12) begin
      errors++;
      $display("[TB] FAIL midrun_rerun_cycle: got %0d expected 12", cycles);
    end
    checks++;
    if ({bus.pass, bus.err_count, bus.fail_vec} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL midrun_rerun_result: got pass=%b err=%0d fail=%b expected pass=1 err=0 fail=0000",
               bus.pass, bus.err_count, bus.fail_vec);
    end
  endtask

  // start held high throughout the run must not restart it.
  task automatic test_start_held();
    int cycles;
    gate_mode = 0;
    start_and_wait(0, 1'b1, cycles);
    checks++;
    if (cycles !== 12) begin
      errors++;
      $display("[TB] FAIL held_start_done_cycle: got %0d expected 12", cycles);
    end
    checks++;
    if (bus.pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_start_pass: got %b expected 1", bus.pass);
    end
  endtask

  // A failing run leaves results in DONE; a start from DONE must clear them
  // one cycle later and then complete a fresh full run.
  task automatic test_back_to_back();
    int cycles;
    gate_mode = 1;
    start_and_wait(0, 1'b0, cycles);
    gate_mode = 0;
    start_and_wait(0, 1'b0, cycles);
    checks++;
    if ({done_at0, pass_at0, err_at0, fail_at0, busy_log[0]} !== {1'b0, 1'b0, 3'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_clear: got done=%b pass=%b err=%0d fail=%b busy=%b expected done=0 pass=0 err=0 fail=0000 busy=1",
               done_at0, pass_at0, err_at0, fail_at0, busy_log[0]);
    end
    checks++;
    if (cycles !== 12) begin
      errors++;
      $display("[TB] FAIL b2b_done_cycle: got %0d expected 12", cycles);
    end
    checks++;
    if ({bus.pass, bus.err_count, bus.fail_vec} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL b2b_result: got pass=%b err=%0d fail=%b expected pass=1 err=0 fail=0000",
               bus.pass, bus.err_count, bus.fail_vec);
    end
  endtask

  // Scenario sequence; every scenario leaves both sequencers idle or done.
  initial begin
    checks      = 0;
    errors      = 0;
    gate_mode   = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus_x.start = 1'b0;

    test_reset();
    test_correct_gate();
    test_stuck_at_one();
    test_wrong_gate();
    test_xor_table();
    test_reset_mid_run();
    test_start_held();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
